// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: accepts a plaintext/key pair, does the initial
// AddRoundKey, drives the round datapath NUM_ROUNDS times and returns the ciphertext.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS  = 10,
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         rnd_rst_,
    output logic [3:0]   rnd_rc,
    output logic [127:0] rnd_data,
    output logic [127:0] rnd_keyin,
    input  logic [127:0] rnd_out,
    input  logic [127:0] rnd_keyout,
    input  logic         rnd_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         timeout_err
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RC_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RC_W-1:0]    r_rc;
    logic [RC_W-1:0]    w_rc_nxt;
    logic [BLK_W-1:0]   r_data;
    logic [BLK_W-1:0]   w_data_nxt;
    logic [BLK_W-1:0]   r_key;
    logic [BLK_W-1:0]   w_key_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_timeout_err;
    logic               w_err_nxt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic [BLK_W-1:0]   r_ciphertext;
    logic               r_rnd_rst_n;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        w_state_nxt = r_state;
        w_rc_nxt    = r_rc;
        w_data_nxt  = r_data;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = plaintext ^ key;
                    w_key_nxt   = key;
                    w_rc_nxt    = RC_W'(1);
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // A done strobe on the final timeout cycle still completes the round
                if (rnd_done) begin
                    w_data_nxt = rnd_out;
                    w_key_nxt  = rnd_keyout;
                    if (r_rc == RC_W'(NUM_ROUNDS)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_rc_nxt    = r_rc + RC_W'(1);
                        w_state_nxt = ST_LOAD;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_err_nxt   = 1'b1;
                w_data_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_rc          <= '0;
            r_data        <= '0;
            r_key         <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_ciphertext  <= '0;
            r_rnd_rst_n   <= 1'b1;
        end else begin
            r_rc          <= w_rc_nxt;
            r_data        <= w_data_nxt;
            r_key         <= w_key_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_err_nxt;
            r_in_ready    <= (w_state_nxt == ST_IDLE);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_out_valid   <= (w_state_nxt == ST_DONE);
            r_ciphertext  <= (w_state_nxt == ST_DONE) ? w_data_nxt : '0;
            r_rnd_rst_n   <= (w_state_nxt != ST_LOAD);
        end
    end

    // Datapath restart also follows the host reset directly
    assign rnd_rst_    = rst_ & r_rnd_rst_n;
    assign rnd_rc      = r_rc;
    assign rnd_data    = r_data;
    assign rnd_keyin   = r_key;
    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign ciphertext  = r_ciphertext;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer with a behavioural AES round datapath and FIPS-197 vectors.
module tb_aes_round_sequencer;

    localparam int unsigned NR  = 10;
    localparam int unsigned TOC = 200;

    logic         clk = 1'b0;
    logic         rst_;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         rnd_rst_;
    logic [3:0]   rnd_rc;
    logic [127:0] rnd_data;
    logic [127:0] rnd_keyin;
    logic [127:0] rnd_out;
    logic [127:0] rnd_keyout;
    logic         rnd_done;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic         timeout_err;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYC(TOC), .CNT_W(8)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .rnd_rst_(rnd_rst_), .rnd_rc(rnd_rc),
        .rnd_data(rnd_data), .rnd_keyin(rnd_keyin), .rnd_out(rnd_out),
        .rnd_keyout(rnd_keyout), .rnd_done(rnd_done), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy),
        .timeout_err(timeout_err)
    );

    int n_checks;
    int n_fail;

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 1; i < int'(rc); i++) rcon = xt(rcon);
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   r [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) r[4*c+rr] = b[4*((c+rr)%4)+rr];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = r[4*c]; a1 = r[4*c+1]; a2 = r[4*c+2]; a3 = r[4*c+3];
                r[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                r[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                r[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                r[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = r[i];
        return o ^ rk;
    endfunction

    // ---------------- round datapath model ----------------
    logic         m_done, m_armed, spur_done;
    int           m_wcnt, dp_delay;
    logic [3:0]   dp_suppress_rc;
    logic [127:0] m_out, m_key, spur_data;

    assign rnd_done   = m_done | spur_done;
    assign rnd_out    = spur_done ? spur_data : m_out;
    assign rnd_keyout = spur_done ? ~spur_data : m_key;

    // Strobe done dp_delay cycles into WAIT, i.e. while the DUT counter equals dp_delay-1
    always @(negedge clk) begin
        if (!rnd_rst_) begin
            m_wcnt  = 0;
            m_armed = (rnd_rc != dp_suppress_rc);
            m_done  = 1'b0;
            m_key   = next_key(rnd_keyin, rnd_rc);
            m_out   = aes_round(rnd_data, m_key, rnd_rc == 4'(NR));
        end else if (m_armed) begin
            m_wcnt++;
            if (m_wcnt == dp_delay) begin
                m_done  = 1'b1;
                m_armed = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // ---------------- LOAD pulse / operand stability monitor ----------------
    int           load_cnt, bad_pulse, unstable;
    logic         prev_low, in_wait;
    logic [3:0]   rc_seq[$];
    logic [127:0] l_data, l_key;
    logic [3:0]   l_rc;

    always begin
        @(negedge clk);
        #1;
        if (!rst_) begin
            prev_low = 1'b0;
            in_wait  = 1'b0;
        end else begin
            if (!busy) in_wait = 1'b0;
            if (!rnd_rst_) begin
                load_cnt++;
                rc_seq.push_back(rnd_rc);
                if (prev_low) bad_pulse++;
                l_data  = rnd_data;
                l_key   = rnd_keyin;
                l_rc    = rnd_rc;
                in_wait = 1'b1;
            end else if (in_wait) begin
                if (rnd_data !== l_data || rnd_keyin !== l_key || rnd_rc !== l_rc) unstable++;
                if (rnd_done) in_wait = 1'b0;
            end
            prev_low = !rnd_rst_;
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_timeout_err"}, timeout_err, 1'b0);
        chk1({tag, "_rnd_rst_low"}, rnd_rst_, 1'b0);
        chk({tag, "_ciphertext"}, ciphertext, 128'h0);
        chk({tag, "_rnd_rc"}, 128'(rnd_rc), 128'h0);
        chk({tag, "_rnd_data"}, rnd_data, 128'h0);
        chk({tag, "_rnd_keyin"}, rnd_keyin, 128'h0);
    endtask

    // Accept one vector, wait for the result, hold it for backp cycles, then release it
    task automatic run_vec(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input int delay, input int backp);
        int  i;
        logic rc_ok;
        dp_delay = delay;
        i = 0;
        while (!in_ready && i < 1000) begin @(negedge clk); i++; end
        chk1("ready_before_accept", in_ready, 1'b1);
        load_cnt = 0; bad_pulse = 0; unstable = 0; rc_seq.delete();
        plaintext = pt; key = k; in_valid = 1'b1;
        @(negedge clk);
        chk1("load_busy", busy, 1'b1);
        chk1("load_in_ready", in_ready, 1'b0);
        chk1("load_rnd_rst", rnd_rst_, 1'b0);
        chk1("load_timeout_err", timeout_err, 1'b0);
        chk("load_rnd_rc", 128'(rnd_rc), 128'h1);
        chk("load_rnd_data", rnd_data, pt ^ k);
        chk("load_rnd_keyin", rnd_keyin, k);
        // in_valid stays high with different data while busy; it must be ignored
        plaintext = ~pt; key = ~k;
        i = 0;
        while (!out_valid && i < 5000) begin @(negedge clk); i++; end
        chk1("out_valid_reached", out_valid, 1'b1);
        chkn("latency", i, int'(NR) * (1 + delay));
        chk("ciphertext", ciphertext, ct);
        chkn("load_pulses", load_cnt, int'(NR));
        chkn("load_pulse_width", bad_pulse, 0);
        chkn("operand_stability", unstable, 0);
        rc_ok = (rc_seq.size() == int'(NR));
        foreach (rc_seq[j]) if (rc_seq[j] !== 4'(j + 1)) rc_ok = 1'b0;
        chk1("rnd_rc_sequence", rc_ok, 1'b1);
        for (int c = 0; c < backp; c++) begin
            spur_done = (c == 1);
            spur_data = {4{32'hdeadbeef}} ^ pt;
            @(negedge clk);
            chk1("hold_out_valid", out_valid, 1'b1);
            chk("hold_ciphertext", ciphertext, ct);
            chk1("hold_in_ready", in_ready, 1'b0);
        end
        spur_done = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("release_out_valid", out_valid, 1'b0);
        chk1("release_in_ready", in_ready, 1'b1);
        chk1("release_busy", busy, 1'b0);
        chk("release_ciphertext", ciphertext, 128'h0);
        chk("release_data_kept", rnd_data, ct);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           delay;
        int           backp;
    } vec_t;

    vec_t vecs [4];

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        n_checks = 0; n_fail = 0;
        rst_ = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        m_done = 1'b0; m_armed = 1'b0; m_wcnt = 0; m_out = '0; m_key = '0;
        dp_delay = 1; dp_suppress_rc = 4'hf; spur_done = 1'b0; spur_data = '0;
        load_cnt = 0; bad_pulse = 0; unstable = 0; prev_low = 1'b0; in_wait = 1'b0;
        l_data = '0; l_key = '0; l_rc = '0;

        vecs[0] = '{C1_PT, C1_KEY, C1_CT, 1, 0};
        vecs[1] = '{B_PT, B_KEY, B_CT, 3, 20};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 3};
        vecs[3] = '{B_PT, B_KEY, B_CT, int'(TOC), 0};

        @(negedge clk);
        chk_reset_vals("reset");
        rst_ = 1'b1;
        @(negedge clk);
        chk1("post_reset_rnd_rst", rnd_rst_, 1'b1);
        chk1("post_reset_in_ready", in_ready, 1'b1);

        foreach (vecs[v]) run_vec(vecs[v].pt, vecs[v].key, vecs[v].ct, vecs[v].delay, vecs[v].backp);

        // Datapath stalls at round 4 -> timeout abort
        dp_suppress_rc = 4'd4; dp_delay = 2;
        plaintext = C1_PT; key = C1_KEY; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        i = 0;
        while (!(rnd_rc == 4'd4 && !rnd_rst_) && i < 1000) begin @(negedge clk); i++; end
        chk1("timeout_reached_rc4", rnd_rst_, 1'b0);
        i = 0;
        while (busy && i < 1000) begin @(negedge clk); i++; end
        chkn("timeout_busy_cycles", i, 1 + int'(TOC) + 1);
        chk1("timeout_err_set", timeout_err, 1'b1);
        chk1("timeout_busy", busy, 1'b0);
        chk1("timeout_in_ready", in_ready, 1'b1);
        chk1("timeout_out_valid", out_valid, 1'b0);
        chk("timeout_data_cleared", rnd_data, 128'h0);
        repeat (3) @(negedge clk);
        chk1("timeout_err_sticky", timeout_err, 1'b1);
        dp_suppress_rc = 4'hf;
        run_vec(C1_PT, C1_KEY, C1_CT, 1, 0);

        // Spurious done while idle must not disturb any register
        spur_data = {$urandom, $urandom, $urandom, $urandom};
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("idle_spur_data", rnd_data, C1_CT);
        chk("idle_spur_key", rnd_keyin, C1_K10);
        chk("idle_spur_rc", 128'(rnd_rc), 128'(NR));
        chk1("idle_spur_busy", busy, 1'b0);
        chk1("idle_spur_out_valid", out_valid, 1'b0);
        chk("idle_spur_ciphertext", ciphertext, 128'h0);

        // Reset in the middle of round 6
        dp_delay = 2;
        plaintext = B_PT; key = B_KEY; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        i = 0;
        while (!(rnd_rc == 4'd6 && rnd_rst_ && busy) && i < 1000) begin @(negedge clk); i++; end
        chk("midrst_reached_rc6", 128'(rnd_rc), 128'h6);
        rst_ = 1'b0;
        #1;
        chk1("midrst_rnd_rst_follows", rnd_rst_, 1'b0);
        @(negedge clk);
        chk_reset_vals("midrst");
        rst_ = 1'b1;
        @(negedge clk);
        chk1("midrst_release_rnd_rst", rnd_rst_, 1'b1);
        run_vec(B_PT, B_KEY, B_CT, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
